// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared glyphs, converter FSM encoding and BCD sizing for m_7segdisp
// Purpose: common definitions for the 7-segment scan controller and its
//          binary-to-BCD converter. No ports (package).
package seg7_pkg;

  // Active-high segment patterns, bit6..0 = a..g; outputs invert them.
  localparam logic [6:0] SEG_DASH  = 7'b0000001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_e;

  // BCD digits needed to hold any unsigned value of the given bit width.
  function automatic int nbcd(input int width);
    return (width + 2) / 3;
  endfunction

  function automatic logic [6:0] seg_glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'h0: g = 7'b1111110;
      4'h1: g = 7'b0110000;
      4'h2: g = 7'b1101101;
      4'h3: g = 7'b1111001;
      4'h4: g = 7'b0110011;
      4'h5: g = 7'b1011011;
      4'h6: g = 7'b1011111;
      4'h7: g = 7'b1110000;
      4'h8: g = 7'b1111111;
      4'h9: g = 7'b1111011;
      4'hA: g = 7'b1110111;
      4'hB: g = 7'b0011111;
      4'hC: g = 7'b1001110;
      4'hD: g = 7'b0111101;
      4'hE: g = 7'b1001111;
      default: g = 7'b1000111;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/m_bin2bcd.sv
// rtl/m_bin2bcd.sv - sequential double-dabble binary-to-BCD converter
// Purpose: converts WIDTH-bit unsigned input to NBCD packed BCD digits,
//          one shift per clock (WIDTH clocks), then a one-cycle done.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset (aborts conversion)
//   start_i       load din_i and begin (accepted only when idle)
//   din_i         binary value
//   busy_o        high during the WIDTH shift cycles
//   done_o        high for one cycle; bcd_o is final while it is high
//   bcd_o         packed BCD result, digit k at [4k+3:4k]
module m_bin2bcd
  import seg7_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NBCD  = 11
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [WIDTH-1:0]  din_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [4*NBCD-1:0] bcd_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  conv_state_e       state_q, state_d;
  logic [WIDTH-1:0]  bin_q, bin_d;
  logic [4*NBCD-1:0] bcd_q, bcd_d, adj;
  logic [CW-1:0]     cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    // Digits >= 5 would become >= 10 after doubling; pre-add 3 so the
    // carry lands in the next BCD digit.
    adj     = bcd_q;
    for (int k = 0; k < NBCD; k++) begin
      if (adj[4*k +: 4] >= 4'd5) adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
    end
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          bin_d   = din_i;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        {bcd_d, bin_d} = {adj[4*NBCD-2:0], bin_q, 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o = (state_q == ST_SHIFT);
  assign done_o = (state_q == ST_DONE);
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/m_7segdisp.sv
// rtl/m_7segdisp.sv - multiplexed DIGITS-digit 7-segment scan controller, hex/decimal
// Purpose: scans DIGITS common-anode digits, DELAY clocks each. Once per
//          frame the pending buffer is committed and a new value sampled;
//          the pending buffer is rebuilt in hex (nibbles) or decimal
//          (via m_bin2bcd), with optional leading-zero blanking and a dash
//          pattern on decimal overflow.
// Ports:
//   w_clk, w_rst  clock, asynchronous active-high reset
//   w_din         value to display
//   w_mode        0 = hex, 1 = unsigned decimal
//   w_blank       1 = suppress leading zeros
//   r_sg          active-low cathodes, bit6..0 = a..g
//   r_an          active-low anodes, one digit low at a time
//   r_busy        decimal conversion running
module m_7segdisp
  import seg7_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int WIDTH  = 32,
  parameter int DELAY  = 100000
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic [WIDTH-1:0]  w_din,
  input  logic              w_mode,
  input  logic              w_blank,
  output logic [6:0]        r_sg,
  output logic [DIGITS-1:0] r_an,
  output logic              r_busy
);

  localparam int NBCD = nbcd(WIDTH);
  localparam int CW   = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam int DW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CW-1:0]     cnt_q;
  logic [DW-1:0]     digit_q;
  logic [6:0]        disp_q [DIGITS];
  logic [6:0]        pend_q [DIGITS];
  logic [6:0]        pend_d [DIGITS];
  logic [WIDTH-1:0]  val_q;
  logic              mode_q, blank_q, hex_wr_q;

  logic              frame_start, take, conv_busy, conv_done;
  logic [4*NBCD-1:0] bcd;

  assign frame_start = (cnt_q == '0) && (digit_q == '0);
  // A frame start while a conversion is still in flight drops the sample.
  assign take        = frame_start && !conv_busy && !conv_done;
  assign r_busy      = conv_busy;

  m_bin2bcd #(
    .WIDTH (WIDTH),
    .NBCD  (NBCD)
  ) u_bin2bcd (
    .clk_i   (w_clk),
    .rst_i   (w_rst),
    .start_i (take && w_mode),
    .din_i   (w_din),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .bcd_o   (bcd)
  );

  // Pending glyphs from the sampled value (hex) or the converter (decimal).
  // Zero-extending to DIGITS nibbles makes digits beyond the value read 0.
  always_comb begin
    logic [4*DIGITS+WIDTH-1:0]  hex_ext;
    logic [4*DIGITS+4*NBCD-1:0] bcd_ext;
    logic [3:0]                 nib;
    logic                       ovf, seen;
    hex_ext = {{(4*DIGITS){1'b0}}, val_q};
    bcd_ext = {{(4*DIGITS){1'b0}}, bcd};
    ovf     = mode_q && (bcd_ext[4*DIGITS +: 4*NBCD] != '0);
    seen    = 1'b0;
    nib     = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib = mode_q ? bcd_ext[4*i +: 4] : hex_ext[4*i +: 4];
      if (nib != 4'd0) seen = 1'b1;
      if (ovf)                              pend_d[i] = SEG_DASH;
      else if (blank_q && !seen && i != 0)  pend_d[i] = SEG_BLANK;
      else                                  pend_d[i] = seg_glyph(nib);
    end
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      cnt_q    <= '0;
      digit_q  <= '0;
      val_q    <= '0;
      mode_q   <= 1'b0;
      blank_q  <= 1'b0;
      hex_wr_q <= 1'b0;
      r_an     <= '1;
      r_sg     <= 7'h7F;
      for (int i = 0; i < DIGITS; i++) begin
        disp_q[i] <= SEG_BLANK;
        pend_q[i] <= SEG_BLANK;
      end
    end else begin
      cnt_q    <= (cnt_q == CW'(DELAY - 1)) ? '0 : cnt_q + CW'(1);
      hex_wr_q <= take && !w_mode;
      if (cnt_q == '0) begin
        r_an    <= ~(DIGITS'(1) << digit_q);
        // Digit 0 of a new frame must show the buffer being committed on
        // this same edge, otherwise it would lag the other digits.
        r_sg    <= ~(frame_start ? pend_q[0] : disp_q[digit_q]);
        digit_q <= (digit_q == DW'(DIGITS - 1)) ? '0 : digit_q + DW'(1);
      end
      if (frame_start) disp_q <= pend_q;
      if (take) begin
        val_q   <= w_din;
        mode_q  <= w_mode;
        blank_q <= w_blank;
      end
      if (hex_wr_q || conv_done) pend_q <= pend_d;
    end
  end

endmodule

// File: tb/tb_m_7segdisp.sv
// tb/tb_m_7segdisp.sv - self-checking bench for m_7segdisp (DIGITS=4, WIDTH=16, DELAY=8)
module tb_m_7segdisp;

  logic        w_clk = 1'b0;
  logic        w_rst;
  logic [15:0] w_din;
  logic        w_mode, w_blank;
  logic [6:0]  r_sg;
  logic [3:0]  r_an;
  logic        r_busy;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [15:0]      din;
    logic             mode;
    logic             blank;
    logic [3:0][6:0]  sg;
  } vec_t;

  vec_t tbl [12];
  logic [3:0][6:0] prev;

  m_7segdisp #(.DIGITS(4), .WIDTH(16), .DELAY(8)) dut (
    .w_clk   (w_clk),
    .w_rst   (w_rst),
    .w_din   (w_din),
    .w_mode  (w_mode),
    .w_blank (w_blank),
    .r_sg    (r_sg),
    .r_an    (r_an),
    .r_busy  (r_busy)
  );

  always #5 w_clk = ~w_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] glyph_ah(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'h0: g = 7'b1111110;  4'h1: g = 7'b0110000;
      4'h2: g = 7'b1101101;  4'h3: g = 7'b1111001;
      4'h4: g = 7'b0110011;  4'h5: g = 7'b1011011;
      4'h6: g = 7'b1011111;  4'h7: g = 7'b1110000;
      4'h8: g = 7'b1111111;  4'h9: g = 7'b1111011;
      4'hA: g = 7'b1110111;  4'hB: g = 7'b0011111;
      4'hC: g = 7'b1001110;  4'hD: g = 7'b0111101;
      4'hE: g = 7'b1001111;  default: g = 7'b1000111;
    endcase
    return g;
  endfunction

  // Expected active-low cathodes per digit from plain arithmetic.
  function automatic logic [3:0][6:0] model(input logic [15:0] v, input logic m, input logic b);
    logic [3:0][6:0] res;
    int unsigned val, base, p, dig, upper;
    logic [6:0] g;
    val  = v;
    base = m ? 10 : 16;
    p    = 1;
    for (int i = 0; i < 4; i++) begin
      upper = val / p;
      dig   = upper % base;
      g     = glyph_ah(dig[3:0]);
      if (b && i > 0 && upper == 0) g = 7'h00;
      if (m && val >= 10000) g = 7'b0000001;
      res[i] = ~g;
      p = p * base;
    end
    return res;
  endfunction

  // Called between edges just before a frame-start edge. Drives the value to
  // be sampled, checks the four digits shown this frame and the busy window.
  task automatic run_frame(input logic [15:0] din, input logic m, input logic b,
                           input logic [3:0][6:0] exp_disp, input string tag);
    int bcnt, bfirst, blast;
    logic [3:0] one;
    one = 4'b0001;
    w_din = din; w_mode = m; w_blank = b;
    bcnt = 0; bfirst = -1; blast = -1;
    for (int c = 0; c < 32; c++) begin
      @(posedge w_clk); #1;
      if (r_busy) begin
        bcnt++;
        if (bfirst < 0) bfirst = c;
        blast = c;
      end
      if (c % 8 == 0) begin
        check($sformatf("%s an%0d", tag, c / 8), {28'd0, r_an}, {28'd0, ~(one << (c / 8))});
        check($sformatf("%s sg%0d", tag, c / 8), {25'd0, r_sg}, {25'd0, exp_disp[c / 8]});
      end
    end
    check($sformatf("%s busy_cycles", tag), bcnt, m ? 16 : 0);
    if (m) begin
      check($sformatf("%s busy_first", tag), bfirst, 0);
      check($sformatf("%s busy_last", tag), blast, 15);
    end
  endtask

  initial begin
    logic [15:0] d;
    logic        m, b;

    tbl[0]  = '{din:16'h1A2F, mode:1'b0, blank:1'b0, sg:{7'b1001111, 7'b0001000, 7'b0010010, 7'b0111000}};
    tbl[1]  = '{din:16'd1234, mode:1'b1, blank:1'b0, sg:{7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}};
    tbl[2]  = '{din:16'd12345, mode:1'b1, blank:1'b0, sg:{4{7'b1111110}}};
    tbl[3]  = '{din:16'h0005, mode:1'b0, blank:1'b1, sg:{7'h7F, 7'h7F, 7'h7F, 7'b0100100}};
    tbl[4]  = '{din:16'h0000, mode:1'b0, blank:1'b1, sg:{7'h7F, 7'h7F, 7'h7F, 7'b0000001}};
    tbl[5]  = '{din:16'h0000, mode:1'b0, blank:1'b0, sg:{4{7'b0000001}}};
    tbl[6]  = '{din:16'd9999, mode:1'b1, blank:1'b1, sg:{4{7'b0000100}}};
    tbl[7]  = '{din:16'd10000, mode:1'b1, blank:1'b1, sg:{4{7'b1111110}}};
    tbl[8]  = '{din:16'd0, mode:1'b1, blank:1'b1, sg:{7'h7F, 7'h7F, 7'h7F, 7'b0000001}};
    tbl[9]  = '{din:16'h0E00, mode:1'b0, blank:1'b1, sg:{7'h7F, 7'b0110000, 7'b0000001, 7'b0000001}};
    tbl[10] = '{din:16'd66, mode:1'b1, blank:1'b1, sg:{7'h7F, 7'h7F, 7'b0100000, 7'b0100000}};
    tbl[11] = '{din:16'hFFFF, mode:1'b0, blank:1'b0, sg:{4{7'b0111000}}};

    w_rst = 1'b1; w_din = '0; w_mode = 1'b0; w_blank = 1'b0;
    repeat (3) @(posedge w_clk);
    #1;
    check("rst an", {28'd0, r_an}, 32'hF);
    check("rst sg", {25'd0, r_sg}, 32'h7F);
    check("rst busy", {31'd0, r_busy}, 32'd0);
    w_rst = 1'b0;
    #1;
    check("rel an", {28'd0, r_an}, 32'hF);
    check("rel sg", {25'd0, r_sg}, 32'h7F);

    prev = {4{7'h7F}};
    for (int v = 0; v < 12; v++) begin
      run_frame(tbl[v].din, tbl[v].mode, tbl[v].blank, prev, $sformatf("vec%0d", v));
      prev = tbl[v].sg;
    end

    for (int r = 0; r < 30; r++) begin
      case ($urandom_range(0, 3))
        0: d = 16'($urandom);
        1: d = 16'($urandom_range(0, 255));
        2: d = 16'($urandom_range(9990, 10010));
        default: d = 16'($urandom_range(0, 15));
      endcase
      m = 1'($urandom);
      b = 1'($urandom);
      run_frame(d, m, b, prev, $sformatf("rnd%0d", r));
      prev = model(d, m, b);
    end

    // Asynchronous reset in the middle of a decimal conversion.
    w_din = 16'd4321; w_mode = 1'b1; w_blank = 1'b0;
    @(posedge w_clk); #1;
    check("mid busy", {31'd0, r_busy}, 32'd1);
    repeat (5) @(posedge w_clk);
    #2 w_rst = 1'b1;
    #1;
    check("async busy", {31'd0, r_busy}, 32'd0);
    check("async an", {28'd0, r_an}, 32'hF);
    check("async sg", {25'd0, r_sg}, 32'h7F);
    @(posedge w_clk); #1;
    w_rst = 1'b0;
    prev = {4{7'h7F}};
    run_frame(16'h00C3, 1'b0, 1'b1, prev, "post_rst0");
    prev = model(16'h00C3, 1'b0, 1'b1);
    run_frame(16'd0, 1'b0, 1'b0, prev, "post_rst1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/m_7segdisp.md
Name: m_7segdisp

Overview:
- Parametrised successor to the board's 8-digit 7-segment scan controller, generalised to DIGITS digits of width-WIDTH input.
- Adds a runtime hex/decimal mode, with a sequential double-dabble binary-to-BCD converter.
- Adds leading-zero blanking and decimal overflow indication.
- Sits beside m_proc11 on the FPGA top, displaying r_rout or the cycle counter.

Parameters:
- DIGITS, 8: number of digits/anodes scanned (1..16).
- WIDTH, 32: input value width (4..32).
- DELAY, 100000: clock cycles each digit stays lit; must satisfy DIGITS*DELAY > WIDTH+4.

Ports:
- w_clk  input  1  system clock.
- w_rst  input  1  asynchronous, active-high reset.
- w_din  input  WIDTH  value to display.
- w_mode  input  1  0 = hexadecimal, 1 = unsigned decimal.
- w_blank  input  1  1 = suppress leading zeros.
- r_sg  output  7  cathodes, active-low, bit6..0 = segments a..g.
- r_an  output  DIGITS  anodes, active-low, one-hot-low.
- r_busy  output  1  high while a decimal conversion is running.

Behaviour:
- Reset (async, w_rst=1):
  - r_an = all ones; r_sg = 7'h7F; r_busy = 0.
  - Scan counter, digit index, display buffer and pending buffer = 0 / blank.
  - Any conversion in progress is aborted.
- Scan:
  - r_cnt counts 0..DELAY-1 and wraps.
  - On each edge where r_cnt==0: r_an drives digit r_digit low, r_sg drives the decoded glyph of display buffer digit r_digit, and r_digit advances 0..DIGITS-1 with wrap.
  - Both outputs are registered and change on the same edge.
- Frame start (edge with r_cnt==0 and r_digit==0):
  - The pending buffer is committed to the display buffer, then w_din, w_mode and w_blank are sampled.
  - A displayed value therefore lags its sample by exactly one frame. There is no tearing within a frame.
- Hex mode: pending buffer = nibbles of the sampled value, written on the cycle after the sample. Digits at or above ceil(WIDTH/4) show 0.
- Decimal mode (FSM IDLE -> SHIFT -> DONE -> IDLE):
  - SHIFT runs WIDTH cycles of add-3-if-≥5 then shift, over NBCD=(WIDTH+2)/3 BCD digits.
  - r_busy is high from the cycle after the sample through the last SHIFT cycle (WIDTH cycles).
  - DONE writes the pending buffer.
  - A frame start occurring while not IDLE cannot happen under the DELAY constraint; if it does, the sample is ignored.
- Overflow: decimal mode with any BCD digit ≥ DIGITS nonzero sets all pending digits to dash (segment g only, r_sg = 7'b1111110).
- Blanking, when the sampled w_blank=1: every digit above the most significant nonzero digit shows blank (7'h7F). Digit 0 is always shown, so the value 0 displays "0".
- Glyphs, active-high before inversion: 0=1111110 1=0110000 2=1101101 3=1111001 4=0110011 5=1011011 6=1011111 7=1110000 8=1111111 9=1111011 A=1110111 b=0011111 C=1001110 d=0111101 E=1001111 F=1000111.

Decomposition:
- Shared package `seg7_pkg`:
  - Glyph constants, including dash and blank.
  - FSM state encoding.
  - NBCD function.
- One sub-module: `m_bin2bcd` (WIDTH parameter; start/busy/done handshake; holds the shift register and add-3 logic).
- Scan, buffering and glyph decode stay in the top module.

Test Plan (DIGITS=4, WIDTH=16, DELAY=8):
1. Reset held, then released → r_an=4'hF, r_sg=7'h7F until the first r_cnt==0 edge; then r_an=4'b1110; anodes rotate 1110→1101→1011→0111 every 8 cycles.
2. Hex w_din=16'h1A2F, w_blank=0 → from the second frame, digits 0..3 show r_sg 0111000 (F), 0010010 (2), 0001000 (A), 1001111 (1).
3. Decimal w_din=16'd1234 → r_busy high exactly 16 cycles after the frame sample; next frame digits 0..3 show 1001100 (4), 0000110 (3), 0010010 (2), 1001111 (1).
4. Decimal w_din=16'd12345 → overflow; next frame all four digits r_sg=7'b1111110.
5. Hex w_din=16'h0005, w_blank=1 → digits 3..1 r_sg=7'h7F, digit 0 r_sg=0100100; w_din=0 → digit 0 shows 0000001.
6. Assert w_rst asynchronously mid-SHIFT → r_busy=0, r_an=4'hF, r_sg=7'h7F before the next clock edge; after release, no stale result is committed.
